// File: rtl/toggle_mon_sg.sv
// Per-net toggle monitor: counts sig transitions over a start-triggered window,
// then streams one (idx, count, sat) beat per net over a valid/ready port.

module toggle_mon_sg_lane #(
    parameter int CNT_W = 16
) (
    input  logic             CP,
    input  logic             RN,
    input  logic             clr,
    input  logic             arm,
    input  logic             cnt_en,
    input  logic             s,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);
    logic prev;

    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            cnt  <= '0;
            sat  <= 1'b0;
            prev <= 1'b0;
        end else begin
            if (arm || cnt_en) prev <= s;
            if (clr) begin
                cnt <= '0;
                sat <= 1'b0;
            end else if (cnt_en && (s != prev)) begin
                // saturate instead of wrapping; sat marks a lost toggle
                if (&cnt) sat <= 1'b1;
                else      cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module toggle_mon_sg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic                     CP,
    input  logic                     RN,
    input  logic                     start,
    input  logic [WIN_W-1:0]         win_len,
    input  logic [WIDTH-1:0]         sig,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     out_valid,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_sat,
    output logic                     done
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DRAIN} state_t;

    state_t                        state;
    logic [WIN_W-1:0]              win_rem;
    logic [IDX_W-1:0]              ptr;
    logic [IDX_W-1:0]              ptr_nxt;
    logic [WIDTH-1:0][CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]              sat;
    logic                          clr;
    logic                          arm;
    logic                          cnt_en;

    assign clr     = (state == IDLE) && start;
    assign arm     = (state == ARM);
    assign cnt_en  = (state == COUNT);
    assign ptr_nxt = ptr + 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        toggle_mon_sg_lane #(.CNT_W(CNT_W)) u_lane (
            .CP     (CP),
            .RN     (RN),
            .clr    (clr),
            .arm    (arm),
            .cnt_en (cnt_en),
            .s      (sig[i]),
            .cnt    (cnt[i]),
            .sat    (sat[i])
        );
    end

    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            win_rem   <= '0;
            ptr       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_rem <= win_len;
                        ptr     <= '0;
                        busy    <= 1'b1;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    state <= (win_rem != '0) ? COUNT : DRAIN;
                end
                COUNT: begin
                    win_rem <= win_rem - 1'b1;
                    if (win_rem == WIN_W'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    // first DRAIN cycle loads beat 0 once the last count has settled
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_idx   <= ptr;
                        out_count <= cnt[ptr];
                        out_sat   <= sat[ptr];
                    end else if (out_ready) begin
                        if (ptr == IDX_W'(WIDTH - 1)) begin
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            out_count <= '0;
                            out_sat   <= 1'b0;
                            ptr       <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ptr       <= ptr_nxt;
                            out_idx   <= ptr_nxt;
                            out_count <= cnt[ptr_nxt];
                            out_sat   <= sat[ptr_nxt];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toggle_mon_sg.sv
// Directed bench for toggle_mon_sg: two instances (wide and 3-bit counters) share
// stimulus; a per-window toggle model feeds expected-beat queues.

module tb_toggle_mon_sg;
    logic        CP = 1'b0;
    logic        RN;
    logic        start;
    logic [15:0] win_len;
    logic [3:0]  sig;
    logic        out_ready;

    logic        busy_a, ov_a, sat_a, done_a;
    logic [1:0]  idx_a;
    logic [15:0] cnt_a;
    logic        busy_b, ov_b, sat_b, done_b;
    logic [1:0]  idx_b;
    logic [2:0]  cnt_b;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { int idx; int cnt; bit sat; } beat_t;
    beat_t qa[$];
    beat_t qb[$];
    int    cap_a[4];
    int    cap_b[4];
    bit    cps_b[4];
    int    exp_tog[4];

    always #5 CP = ~CP;

    toggle_mon_sg #(.WIDTH(4), .CNT_W(16), .WIN_W(16)) dut_a (
        .CP(CP), .RN(RN), .start(start), .win_len(win_len), .sig(sig),
        .out_ready(out_ready), .busy(busy_a), .out_valid(ov_a), .out_idx(idx_a),
        .out_count(cnt_a), .out_sat(sat_a), .done(done_a));

    toggle_mon_sg #(.WIDTH(4), .CNT_W(3), .WIN_W(16)) dut_b (
        .CP(CP), .RN(RN), .start(start), .win_len(win_len), .sig(sig),
        .out_ready(out_ready), .busy(busy_b), .out_valid(ov_b), .out_idx(idx_b),
        .out_count(cnt_b), .out_sat(sat_b), .done(done_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus patterns, indexed by sample edge k (k=1 is the ARM edge)
    function automatic logic [3:0] pat(input int mode, input int k);
        logic [3:0] v;
        v = 4'b0;
        case (mode)
            0: begin
                v[0] = k[0];
                v[1] = 1'b1;
                v[2] = (k >= 3);
                v[3] = (k >= 2 && k < 5);
            end
            1: v[0] = k[0];
            default: begin
                v[0] = (k >= 3);
                v[1] = k[1];
            end
        endcase
        return v;
    endfunction

    // One compare process: beats must match the queue head; idle outputs must be zero
    always @(negedge CP) begin
        if (ov_a) begin
            if (qa.size() == 0) chk("a_extra_beat", 1, 0);
            else begin
                chk("a_idx", idx_a, qa[0].idx);
                chk("a_cnt", cnt_a, qa[0].cnt);
                chk("a_sat", sat_a, qa[0].sat);
                if (out_ready) begin
                    cap_a[qa[0].idx] = cnt_a;
                    void'(qa.pop_front());
                end
            end
        end else chk("a_idle_zero", {idx_a, cnt_a, sat_a}, 0);
        if (ov_b) begin
            if (qb.size() == 0) chk("b_extra_beat", 1, 0);
            else begin
                chk("b_idx", idx_b, qb[0].idx);
                chk("b_cnt", cnt_b, qb[0].cnt);
                chk("b_sat", sat_b, qb[0].sat);
                if (out_ready) begin
                    cap_b[qb[0].idx] = cnt_b;
                    cps_b[qb[0].idx] = sat_b;
                    void'(qb.pop_front());
                end
            end
        end else chk("b_idle_zero", {idx_b, cnt_b, sat_b}, 0);
    end

    task automatic run_window(input int wl, input int mode, input bit stall,
                              input bit chained, input int restart_k);
        logic [3:0] hist [0:63];
        int n, c;
        bit rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 1; k <= wl + 1; k++) hist[k] = pat(mode, k);
        for (int i = 0; i < 4; i++) begin
            exp_tog[i] = 0;
            for (int k = 2; k <= wl + 1; k++)
                if (hist[k][i] != hist[k-1][i]) exp_tog[i]++;
            qa.push_back('{idx: i, cnt: exp_tog[i], sat: 1'b0});
            qb.push_back('{idx: i, cnt: (exp_tog[i] > 7) ? 7 : exp_tog[i], sat: (exp_tog[i] > 7)});
        end
        if (chained) chk("done_cycle", done_a, 1);
        else begin
            @(posedge CP); #1;
            chk("done_single_pulse", done_a, 0);
        end
        start = 1'b1; win_len = 16'(wl); out_ready = 1'b1;
        @(posedge CP); #1;
        start = 1'b0;
        chk("busy_after_start", busy_a, 1);
        for (int k = 1; k <= wl + 1; k++) begin
            sig = hist[k];
            start = (k == restart_k);
            @(posedge CP); #1;
        end
        start = 1'b0;
        n = wl + 1;
        while (!ov_a && n < wl + 50) begin
            @(posedge CP); #1;
            n++;
        end
        chk("first_beat_latency", n, wl + 2);
        c = 0;
        while (!done_a && c < 100) begin
            out_ready = stall ? rp[c % 4] : 1'b1;
            @(posedge CP); #1;
            c++;
        end
        out_ready = 1'b1;
        chk("done_a", done_a, 1);
        chk("done_b", done_b, 1);
        chk("busy_after_done", {busy_a, busy_b, ov_a}, 0);
        chk("beats_left_a", qa.size(), 0);
        chk("beats_left_b", qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RN = 1'b0; start = 1'b0; win_len = '0; sig = '0; out_ready = 1'b1;
        #1;
        chk("reset_a", {busy_a, ov_a, idx_a, cnt_a, sat_a, done_a}, 0);
        chk("reset_b", {busy_b, ov_b, idx_b, cnt_b, sat_b, done_b}, 0);
        repeat (3) @(posedge CP);
        #1 RN = 1'b1;

        // Basic window: counts 8,0,1,2
        run_window(8, 0, 1'b0, 1'b0, 0);
        chk("model_pin_0", exp_tog[0], 8);
        chk("model_pin_3", exp_tog[3], 2);
        chk("lit_a0", cap_a[0], 8);
        chk("lit_a1", cap_a[1], 0);
        chk("lit_a2", cap_a[2], 1);
        chk("lit_a3", cap_a[3], 2);

        // Saturation on the 3-bit instance
        run_window(12, 1, 1'b0, 1'b0, 0);
        chk("lit_b0_cnt", cap_b[0], 7);
        chk("lit_b0_sat", cps_b[0], 1);
        chk("lit_b1_cnt", cap_b[1], 0);
        chk("lit_b1_sat", cps_b[1], 0);
        chk("lit_a0_12", cap_a[0], 12);

        // Zero-length window
        run_window(0, 0, 1'b0, 1'b0, 0);
        chk("lit_zero_a0", cap_a[0], 0);

        // Back-pressure 1,0,0,1 during drain
        run_window(10, 0, 1'b1, 1'b0, 0);

        // Second start mid-COUNT is ignored
        run_window(20, 2, 1'b0, 1'b0, 6);

        // Start in the done cycle
        run_window(5, 0, 1'b0, 1'b0, 0);
        run_window(6, 2, 1'b0, 1'b1, 0);
        chk("lit_chain_a0", cap_a[0], 1);
        chk("lit_chain_a1", cap_a[1], 3);

        // Reset mid-COUNT discards the window
        @(posedge CP); #1;
        start = 1'b1; win_len = 16'd20;
        @(posedge CP); #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sig = ~sig;
            @(posedge CP); #1;
        end
        chk("busy_mid_count", busy_a, 1);
        #2 RN = 1'b0;
        #1;
        chk("rst_mid_a", {busy_a, ov_a, idx_a, cnt_a, sat_a, done_a}, 0);
        chk("rst_mid_b", {busy_b, ov_b, idx_b, cnt_b, sat_b, done_b}, 0);
        @(posedge CP); #1 RN = 1'b1;
        for (int k = 0; k < 30; k++) begin
            sig = ~sig;
            @(posedge CP); #1;
            chk("no_done_after_rst", {done_a, done_b, busy_a, ov_a}, 0);
        end

        // Resume after reset
        run_window(4, 1, 1'b0, 1'b0, 0);
        chk("lit_resume_a0", cap_a[0], 4);
        @(posedge CP); #1;
        chk("done_single_end", done_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
